// File: rtl/button_conditioner_pkg.sv
// Shared definitions for the button conditioner: debounce state encoding,
// channel indices and counter sizing helper.
package button_conditioner_pkg;

  localparam logic [1:0] ST_IDLE         = 2'd0;
  localparam logic [1:0] ST_PRESS_WAIT   = 2'd1;
  localparam logic [1:0] ST_PRESSED      = 2'd2;
  localparam logic [1:0] ST_RELEASE_WAIT = 2'd3;

  localparam int DEFAULT_DEBOUNCE_CYCLES = 1_000_000;

  localparam int NUM_CH   = 6;
  localparam int CH_ONE   = 0;
  localparam int CH_TWO   = 1;
  localparam int CH_THREE = 2;
  localparam int CH_PAUSE = 3;
  localparam int CH_RSTPT = 4;
  localparam int CH_TEAM  = 5;

  // Bits needed to hold 0..max_val, never less than one.
  function automatic int cnt_width(input int max_val);
    if (max_val < 1) begin
      return 1;
    end else begin
      return $clog2(max_val + 1);
    end
  endfunction

endpackage

// File: rtl/button_conditioner_debounce_channel.sv
// One raw input: synchroniser chain followed by a four-state debounce FSM
// producing a clean level and a single-cycle rise strobe.
module debounce_channel
  import button_conditioner_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter int SYNC_STAGES     = 2,
  parameter bit REQUIRE_RELEASE = 1'b1
) (
  input  logic clock,
  input  logic reset,
  input  logic i_raw,
  output logic o_level,
  output logic o_rise
);

  localparam int               CNT_W    = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] r_sync;
  logic [SYNC_STAGES-1:0] r_fill;
  logic                   r_armed;
  logic [1:0]             r_state;
  logic [CNT_W-1:0]       r_cnt;
  logic                   r_level;
  logic                   r_rise;

  logic             w_in;
  logic             w_valid;
  logic [CNT_W-1:0] w_cnt_inc;

  assign w_in      = r_sync[SYNC_STAGES-1];
  assign w_valid   = r_fill[SYNC_STAGES-1];
  assign w_cnt_inc = r_cnt + CNT_W'(1);

  // r_fill marks when the chain output holds a sample taken after reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_sync <= {SYNC_STAGES{1'b0}};
      r_fill <= {SYNC_STAGES{1'b0}};
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_raw};
      r_fill <= {r_fill[SYNC_STAGES-2:0], 1'b1};
    end
  end

  // Buttons must be seen released once after reset before a press can count.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_cnt   <= CNT_W'(0);
      r_level <= 1'b0;
      r_rise  <= 1'b0;
      r_armed <= 1'b0;
    end else begin
      r_rise <= 1'b0;
      if (w_valid && !w_in) begin
        r_armed <= 1'b1;
      end
      case (r_state)
        ST_IDLE: begin
          r_level <= 1'b0;
          if (w_in && (r_armed || !REQUIRE_RELEASE)) begin
            r_state <= ST_PRESS_WAIT;
            r_cnt   <= CNT_W'(0);
          end
        end
        ST_PRESS_WAIT: begin
          if (!w_in) begin
            r_state <= ST_IDLE;
          end else if (w_cnt_inc == CNT_LAST) begin
            r_state <= ST_PRESSED;
            r_level <= 1'b1;
            r_rise  <= 1'b1;
          end else begin
            r_cnt <= w_cnt_inc;
          end
        end
        ST_PRESSED: begin
          if (!w_in) begin
            r_state <= ST_RELEASE_WAIT;
            r_cnt   <= CNT_W'(0);
          end
        end
        ST_RELEASE_WAIT: begin
          if (w_in) begin
            r_state <= ST_PRESSED;
          end else if (w_cnt_inc == CNT_LAST) begin
            r_state <= ST_IDLE;
            r_level <= 1'b0;
          end else begin
            r_cnt <= w_cnt_inc;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_level <= 1'b0;
        end
      endcase
    end
  end

  assign o_level = r_level;
  assign o_rise  = r_rise;

endmodule

// File: rtl/button_conditioner.sv
// Scoreboard button front end: six debounced channels, score arbitration with
// a shared pulse stretcher and lockout, reset-points pulse, pause toggle, team level.
module button_conditioner
  import button_conditioner_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter int SYNC_STAGES     = 2,
  parameter int PULSE_CYCLES    = 1,
  parameter int LOCKOUT_CYCLES  = 0
) (
  input  logic clock,
  input  logic reset,
  input  logic btn_one_raw,
  input  logic btn_two_raw,
  input  logic btn_three_raw,
  input  logic btn_pause_raw,
  input  logic btn_rstpt_raw,
  input  logic sw_team_raw,
  output logic one_point,
  output logic two_point,
  output logic three_point,
  output logic reset_points,
  output logic pause,
  output logic team
);

  localparam int PW = cnt_width(PULSE_CYCLES);
  localparam int LW = cnt_width(LOCKOUT_CYCLES);

  logic [NUM_CH-1:0] w_raw;
  logic [NUM_CH-1:0] w_level;
  logic [NUM_CH-1:0] w_rise;
  logic              w_unused;

  logic [PW-1:0] r_score_cnt;
  logic [LW-1:0] r_lock_cnt;
  logic [PW-1:0] r_rst_cnt;
  logic          r_one_point;
  logic          r_two_point;
  logic          r_three_point;
  logic          r_reset_points;
  logic          r_pause;
  logic          r_team;

  logic w_score_free;
  logic w_acc_one;
  logic w_acc_two;
  logic w_acc_three;
  logic w_acc_any;

  assign w_raw = {sw_team_raw, btn_rstpt_raw, btn_pause_raw,
                  btn_three_raw, btn_two_raw, btn_one_raw};

  genvar g;
  generate
    for (g = 0; g < NUM_CH; g++) begin : g_chan
      debounce_channel #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .SYNC_STAGES     (SYNC_STAGES),
        .REQUIRE_RELEASE (g != CH_TEAM)
      ) u_chan (
        .clock   (clock),
        .reset   (reset),
        .i_raw   (w_raw[g]),
        .o_level (w_level[g]),
        .o_rise  (w_rise[g])
      );
    end
  endgenerate

  assign w_unused = &{1'b0, w_level[CH_RSTPT:CH_ONE], w_rise[CH_TEAM]};

  // Fixed priority one > two > three; losers and blocked strobes are dropped.
  always_comb begin
    w_score_free = (r_score_cnt == PW'(0)) && (r_lock_cnt == LW'(0));
    w_acc_one    = 1'b0;
    w_acc_two    = 1'b0;
    w_acc_three  = 1'b0;
    if (!w_score_free) begin
      w_acc_one = 1'b0;
    end else if (w_rise[CH_ONE]) begin
      w_acc_one = 1'b1;
    end else if (w_rise[CH_TWO]) begin
      w_acc_two = 1'b1;
    end else if (w_rise[CH_THREE]) begin
      w_acc_three = 1'b1;
    end else begin
      w_acc_one = 1'b0;
    end
    w_acc_any = w_acc_one | w_acc_two | w_acc_three;
  end

  // Shared score pulse counter; lockout loads as the last pulse cycle expires.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_score_cnt   <= PW'(0);
      r_lock_cnt    <= LW'(0);
      r_one_point   <= 1'b0;
      r_two_point   <= 1'b0;
      r_three_point <= 1'b0;
    end else if (w_acc_any) begin
      r_score_cnt   <= PW'(PULSE_CYCLES);
      r_one_point   <= w_acc_one;
      r_two_point   <= w_acc_two;
      r_three_point <= w_acc_three;
    end else if (r_score_cnt != PW'(0)) begin
      r_score_cnt <= r_score_cnt - PW'(1);
      if (r_score_cnt == PW'(1)) begin
        r_one_point   <= 1'b0;
        r_two_point   <= 1'b0;
        r_three_point <= 1'b0;
        r_lock_cnt    <= LW'(LOCKOUT_CYCLES);
      end
    end else if (r_lock_cnt != LW'(0)) begin
      r_lock_cnt <= r_lock_cnt - LW'(1);
    end
  end

  // Independent reset-points pulse stretcher.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_rst_cnt      <= PW'(0);
      r_reset_points <= 1'b0;
    end else if (w_rise[CH_RSTPT] && (r_rst_cnt == PW'(0))) begin
      r_rst_cnt      <= PW'(PULSE_CYCLES);
      r_reset_points <= 1'b1;
    end else if (r_rst_cnt != PW'(0)) begin
      r_rst_cnt <= r_rst_cnt - PW'(1);
      if (r_rst_cnt == PW'(1)) begin
        r_reset_points <= 1'b0;
      end
    end
  end

  // Pause toggle and registered team level.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_pause <= 1'b0;
      r_team  <= 1'b0;
    end else begin
      if (w_rise[CH_PAUSE]) begin
        r_pause <= ~r_pause;
      end
      r_team <= w_level[CH_TEAM];
    end
  end

  assign one_point    = r_one_point;
  assign two_point    = r_two_point;
  assign three_point  = r_three_point;
  assign reset_points = r_reset_points;
  assign pause        = r_pause;
  assign team         = r_team;

endmodule
